// File: rtl/vrased_reset_ctrl_if.sv
// Signal bundle between the VRASED sub-monitors, the reset/wipe sequencer
// and the MCU reset/RAM ports.
interface vrased_reset_ctrl_if;
    logic        viol_xstack;
    logic        viol_ac;
    logic        viol_atom;
    logic        viol_dma;
    logic        clr_ram_req;
    logic        cause_clr;
    logic        cpu_reset;
    logic        wipe_we;
    logic [15:0] wipe_addr;
    logic        wipe_done;
    logic        busy;
    logic [3:0]  viol_cause;
    logic [7:0]  viol_count;

    modport master (
        output viol_xstack, viol_ac, viol_atom, viol_dma,
        output clr_ram_req, cause_clr,
        input  cpu_reset, wipe_we, wipe_addr, wipe_done,
        input  busy, viol_cause, viol_count
    );

    modport slave (
        input  viol_xstack, viol_ac, viol_atom, viol_dma,
        input  clr_ram_req, cause_clr,
        output cpu_reset, wipe_we, wipe_addr, wipe_done,
        output busy, viol_cause, viol_count
    );
endinterface

// File: rtl/vrased_reset_ctrl.sv
// VRASED reset/wipe sequencer: holds the MCU in reset, wipes RAM, releases.
// Define VRASED_VIOL_COUNT_EN to enable the saturating viol_count counter.
module vrased_reset_ctrl #(
    parameter int          HOLD_CYCLES = 4,
    parameter logic [15:0] WIPE_BASE   = 16'h0200,
    parameter int          WIPE_WORDS  = 256,
    parameter int          WIPE_STEP   = 2
) (
    input  logic               clk,
    input  logic               reset,
    vrased_reset_ctrl_if.slave bus
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int WW = (WIPE_WORDS > 1) ? $clog2(WIPE_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        WIPE,
        RELEASE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [HW-1:0]   hold_cnt;
    logic [HW-1:0]   hold_nxt;
    logic [WW-1:0]   word_cnt;
    logic [WW-1:0]   word_nxt;
    logic [15:0]     addr_nxt;
    logic [3:0]      viol_vec;
    logic [3:0]      cause_nxt;
    logic            any_viol;

    assign viol_vec = {bus.viol_dma, bus.viol_atom,
                       bus.viol_ac, bus.viol_xstack};
    assign any_viol = |viol_vec;

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        word_nxt  = word_cnt;
        addr_nxt  = bus.wipe_addr;
        unique case (state)
            IDLE: begin
                if (any_viol || bus.clr_ram_req) begin
                    state_nxt = ASSERT;
                    hold_nxt  = '0;
                end
            end
            ASSERT: begin
                // a fresh violation restarts the full hold period
                if (any_viol) begin
                    hold_nxt = '0;
                end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                    state_nxt = WIPE;
                    hold_nxt  = '0;
                    word_nxt  = '0;
                    addr_nxt  = WIPE_BASE;
                end else begin
                    hold_nxt = hold_cnt + HW'(1);
                end
            end
            WIPE: begin
                if (word_cnt == WW'(WIPE_WORDS - 1)) begin
                    state_nxt = RELEASE;
                    addr_nxt  = WIPE_BASE;
                end else begin
                    word_nxt = word_cnt + WW'(1);
                    addr_nxt = bus.wipe_addr + 16'(WIPE_STEP);
                end
            end
            RELEASE: begin
                state_nxt = any_viol ? ASSERT : IDLE;
                hold_nxt  = '0;
            end
            default: begin
                state_nxt = ASSERT;
                hold_nxt  = '0;
            end
        endcase
        // a new pulse wins over a clear landing on the same edge
        cause_nxt = (bus.cause_clr ? 4'b0000 : bus.viol_cause) | viol_vec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ASSERT;
            hold_cnt       <= '0;
            word_cnt       <= '0;
            bus.cpu_reset  <= 1'b1;
            bus.busy       <= 1'b1;
            bus.wipe_we    <= 1'b0;
            bus.wipe_addr  <= WIPE_BASE;
            bus.wipe_done  <= 1'b0;
            bus.viol_cause <= 4'b0000;
        end else begin
            state          <= state_nxt;
            hold_cnt       <= hold_nxt;
            word_cnt       <= word_nxt;
            bus.cpu_reset  <= (state_nxt != IDLE);
            bus.busy       <= (state_nxt != IDLE);
            bus.wipe_we    <= (state_nxt == WIPE);
            bus.wipe_addr  <= addr_nxt;
            bus.wipe_done  <= (state_nxt == RELEASE);
            bus.viol_cause <= cause_nxt;
        end
    end

`ifdef VRASED_VIOL_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.viol_count <= 8'h00;
        end else if (any_viol && (bus.viol_count != 8'hFF)) begin
            bus.viol_count <= bus.viol_count + 8'd1;
        end
    end
`else
    assign bus.viol_count = 8'h00;
`endif
endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Directed bench for vrased_reset_ctrl with HOLD_CYCLES=4, WIPE_WORDS=8,
// WIPE_BASE=0200, WIPE_STEP=2.
module tb_vrased_reset_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;

    vrased_reset_ctrl_if bus();

    vrased_reset_ctrl #(
        .HOLD_CYCLES(4),
        .WIPE_BASE  (16'h0200),
        .WIPE_WORDS (8),
        .WIPE_STEP  (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v;
        logic       clr;
        logic       cc;
        logic       cpu;
        logic       busy;
        logic [3:0] cause;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_cnt = 8'h00;
    logic [5:0] inj [13];
    vec_t       tbl [8];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic clr,
                         input logic cc);
        {bus.viol_dma, bus.viol_atom, bus.viol_ac, bus.viol_xstack} = v;
        bus.clr_ram_req = clr;
        bus.cause_clr   = cc;
    endtask

    task automatic tick();
`ifdef VRASED_VIOL_COUNT_EN
        if (!reset && (bus.viol_dma || bus.viol_atom || bus.viol_ac ||
                       bus.viol_xstack) && exp_cnt != 8'hFF)
            exp_cnt = exp_cnt + 8'd1;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] v, input logic clr,
                         input logic cc);
        drive(v, clr, cc);
        tick();
        drive(4'b0000, 1'b0, 1'b0);
    endtask

    // Checks one full 13-cycle sequence starting at the first ASSERT cycle.
    task automatic run_seq(input string nm, input bit idle_after);
        bit w;
        for (int k = 0; k < 13; k++) begin
            w = (k >= 4) && (k < 12);
            chk({nm, ".cpu_reset"}, 16'(bus.cpu_reset), 16'd1);
            chk({nm, ".busy"}, 16'(bus.busy), 16'd1);
            chk({nm, ".wipe_we"}, 16'(bus.wipe_we), 16'(w));
            chk({nm, ".wipe_addr"}, bus.wipe_addr,
                w ? 16'h0200 + 16'(2 * (k - 4)) : 16'h0200);
            chk({nm, ".wipe_done"}, 16'(bus.wipe_done), 16'(k == 12));
            pulse(inj[k][5:2], inj[k][1], inj[k][0]);
            inj[k] = '0;
        end
        chk({nm, ".after_cpu"}, 16'(bus.cpu_reset), 16'(!idle_after));
        chk({nm, ".after_busy"}, 16'(bus.busy), 16'(!idle_after));
        chk({nm, ".after_done"}, 16'(bus.wipe_done), 16'd0);
        chk({nm, ".count"}, 16'(bus.viol_count), 16'(exp_cnt));
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".cpu_reset"}, 16'(bus.cpu_reset), 16'd1);
        chk({nm, ".busy"}, 16'(bus.busy), 16'd1);
        chk({nm, ".wipe_we"}, 16'(bus.wipe_we), 16'd0);
        chk({nm, ".wipe_addr"}, bus.wipe_addr, 16'h0200);
        chk({nm, ".wipe_done"}, 16'(bus.wipe_done), 16'd0);
        chk({nm, ".cause"}, 16'(bus.viol_cause), 16'h0);
        chk({nm, ".count"}, 16'(bus.viol_count), 16'h00);
    endtask

    initial begin
        tbl[0] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[1] = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
        tbl[2] = '{4'b0010, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0010};
        tbl[3] = '{4'b1100, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1110};
        tbl[4] = '{4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000};
        tbl[5] = '{4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001};
        tbl[6] = '{4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001};
        tbl[7] = '{4'b1001, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1001};
        for (int i = 0; i < 13; i++) inj[i] = '0;
        drive(4'b0000, 1'b0, 1'b0);

        // boot-time wipe
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        #2 reset = 1'b0;
        run_seq("boot", 1'b1);

        // violation from IDLE, sticky cause, cause_clr
        pulse(4'b0010, 1'b0, 1'b0);
        run_seq("ac", 1'b1);
        chk("ac.cause", 16'(bus.viol_cause), 16'h2);
        tick();
        chk("ac.cause_sticky", 16'(bus.viol_cause), 16'h2);
        pulse(4'b0000, 1'b0, 1'b1);
        chk("ac.cause_clr", 16'(bus.viol_cause), 16'h0);

        // table: cause set/clear priority, clr_ram_req in ASSERT
        for (int i = 0; i < 8; i++) begin
            pulse(tbl[i].v, tbl[i].clr, tbl[i].cc);
            chk($sformatf("tbl%0d.cpu_reset", i),
                16'(bus.cpu_reset), 16'(tbl[i].cpu));
            chk($sformatf("tbl%0d.busy", i), 16'(bus.busy), 16'(tbl[i].busy));
            chk($sformatf("tbl%0d.cause", i),
                16'(bus.viol_cause), 16'(tbl[i].cause));
        end
        chk("tbl.count", 16'(bus.viol_count), 16'(exp_cnt));
        run_seq("tbl_tail", 1'b1);

        // clr_ram_req in IDLE starts a sequence, in WIPE is ignored
        pulse(4'b0000, 1'b1, 1'b0);
        chk("clr.cause_kept", 16'(bus.viol_cause), 16'h9);
        inj[6] = 6'b0000_10;
        run_seq("clr_in_wipe", 1'b1);
        chk("clr.cause_after", 16'(bus.viol_cause), 16'h9);

        // violation in 3rd ASSERT cycle restarts the hold
        pulse(4'b0000, 1'b0, 1'b1);
        chk("xs.cause_clr", 16'(bus.viol_cause), 16'h0);
        pulse(4'b0000, 1'b1, 1'b0);
        tick();
        tick();
        chk("xs.still_assert", 16'(bus.wipe_we), 16'd0);
        pulse(4'b0001, 1'b0, 1'b0);
        run_seq("xs_restart", 1'b1);
        chk("xs.cause", 16'(bus.viol_cause), 16'h1);

        // DMA in WIPE logged only; atomicity in RELEASE re-enters ASSERT
        pulse(4'b0000, 1'b0, 1'b1);
        pulse(4'b0000, 1'b1, 1'b0);
        inj[8]  = 6'b1000_00;
        inj[12] = 6'b0100_00;
        run_seq("dma_wipe", 1'b0);
        chk("rel.cause", 16'(bus.viol_cause), 16'hC);
        run_seq("atom_rel", 1'b1);

        // long violation burst saturates the counter
        drive(4'b0010, 1'b0, 1'b0);
        repeat (300) tick();
        drive(4'b0000, 1'b0, 1'b0);
`ifdef VRASED_VIOL_COUNT_EN
        chk("cnt.sat", 16'(bus.viol_count), 16'h00FF);
`else
        chk("cnt.tied", 16'(bus.viol_count), 16'h0000);
`endif
        chk("cnt.model", 16'(bus.viol_count), 16'(exp_cnt));

        // asynchronous reset in the middle of WIPE
        repeat (6) tick();
        chk("mid.wipe_we", 16'(bus.wipe_we), 16'd1);
        chk("mid.wipe_addr", bus.wipe_addr, 16'h0204);
        #2 reset = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        exp_cnt = 8'h00;
        @(posedge clk);
        #2 reset = 1'b0;
        run_seq("reboot", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
